// File: rtl/cdc_synchron.sv
//-----------------------------------------------------------------------------
// cdc_synchron
//
// Purpose:
//   Brings an asynchronous (foreign-domain) input into the sysClk_i domain
//   through a multi-flop synchronizer chain. The block outputs the
//   synchronized level together with single-cycle rising- and falling-edge
//   strobes. Each bit of a vector is synchronized on its own, so no coherency
//   between bits is implied.
//
// Parameters:
//   WIDTH        number of independent bits synchronized in parallel
//   STAGES       synchronizer flop count, meaningful range 2..4
//   RESET_VALUE  level loaded into every chain stage and the history flop
//                on reset (the same value for all bits)
//
// Ports:
//   sysClk_i   in   1      destination-domain clock, rising edge active
//   reset_i    in   1      asynchronous, active-low reset
//   async_i    in   WIDTH  asynchronous input, no timing relation to sysClk_i
//   sync_o     out  WIDTH  synchronized level (last chain stage)
//   rising_o   out  WIDTH  one-cycle strobe on a 0->1 change of sync_o
//   falling_o  out  WIDTH  one-cycle strobe on a 1->0 change of sync_o
//-----------------------------------------------------------------------------
`timescale 1ns / 1ps

module cdc_synchron #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned STAGES      = 2,
  parameter bit          RESET_VALUE = 1'b0
) (
  input  logic             sysClk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rising_o,
  output logic [WIDTH-1:0] falling_o
);

  // A single flop gives no metastability protection and more than four
  // stages buys nothing but latency, so the chain length is held to 2..4.
  localparam int unsigned CHAIN = (STAGES < 2) ? 2 : ((STAGES > 4) ? 4 : STAGES);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Synchronizer chain: index 0 samples the asynchronous input and
      // index CHAIN-1 is the first flop that is considered stable. The
      // ASYNC_REG attribute keeps the flops packed together. It also stops
      // synthesis from retiming the chain or merging it into other logic.
      (* ASYNC_REG = "TRUE" *) logic [CHAIN-1:0] sync_chain_q;
      logic [CHAIN-1:0]                          sync_chain_d;

      // The history flop holds the previous value of the last stage. This
      // is what edge detection compares against.
      logic prev_q;
      logic prev_d;

      // Shift the raw input in at the bottom of the chain.
      assign sync_chain_d = {sync_chain_q[CHAIN-2:0], async_i[gi]};
      assign prev_d       = sync_chain_q[CHAIN-1];

      // Reset loads the same level into the chain and the history flop.
      // As a result, neither asserting nor releasing reset can create an
      // edge strobe.
      always_ff @(posedge sysClk_i or negedge reset_i) begin
        if (!reset_i) begin
          sync_chain_q <= {CHAIN{RESET_VALUE}};
          prev_q       <= RESET_VALUE;
        end else begin
          sync_chain_q <= sync_chain_d;
          prev_q       <= prev_d;
        end
      end

      // All outputs are decoded only from flops. No path runs from async_i
      // to an output. The strobes are mutually exclusive by construction.
      assign sync_o[gi]    = sync_chain_q[CHAIN-1];
      assign rising_o[gi]  = sync_chain_q[CHAIN-1] & ~prev_q;
      assign falling_o[gi] = ~sync_chain_q[CHAIN-1] & prev_q;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_synchron.sv
`timescale 1ns / 1ps

module tb_cdc_synchron;

  localparam int W   = 4;
  localparam int S_A = 2;
  localparam int S_B = 3;
  localparam logic [W-1:0] RV_A = '0;
  localparam logic [W-1:0] RV_B = '1;

  typedef struct {
    logic [W-1:0] sync;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] async_i;
  logic [W-1:0] sync_a, rise_a, fall_a;
  logic [W-1:0] sync_b, rise_b, fall_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: one queue of expected responses per DUT.
  exp_t         q_a[$];
  exp_t         q_b[$];
  logic [W-1:0] last_a = RV_A;
  logic [W-1:0] last_b = RV_B;
  int           edge_cnt = 0;
  int           rcnt_a = 0, fcnt_a = 0, rcnt_b = 0, fcnt_b = 0;

  always #5 clk = ~clk;

  cdc_synchron #(.WIDTH(W), .STAGES(S_A), .RESET_VALUE(1'b0)) dut_a (
    .sysClk_i (clk),
    .reset_i  (reset_i),
    .async_i  (async_i),
    .sync_o   (sync_a),
    .rising_o (rise_a),
    .falling_o(fall_a)
  );

  cdc_synchron #(.WIDTH(W), .STAGES(S_B), .RESET_VALUE(1'b1)) dut_b (
    .sysClk_i (clk),
    .reset_i  (reset_i),
    .async_i  (async_i),
    .sync_o   (sync_b),
    .rising_o (rise_b),
    .falling_o(fall_b)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the level seen at clock edge j appears on sync_o STAGES-1 edges
  // later. An edge strobe marks the first cycle of each new level. Each
  // sampled input pushes its expected response here. The monitor pops it
  // once the delay has elapsed.
  initial forever begin
    @(posedge clk);
    if (!reset_i) begin
      q_a.delete();
      q_b.delete();
      last_a   = RV_A;
      last_b   = RV_B;
      edge_cnt = 0;
      rcnt_a = 0; fcnt_a = 0; rcnt_b = 0; fcnt_b = 0;
    end else begin
      q_a.push_back('{sync: async_i, rise: async_i & ~last_a, fall: ~async_i & last_a});
      q_b.push_back('{sync: async_i, rise: async_i & ~last_b, fall: ~async_i & last_b});
      last_a = async_i;
      last_b = async_i;
      edge_cnt++;
    end
    #1;
    if (!reset_i) begin
      chk("rst_sync_a", sync_a, RV_A);
      chk("rst_rise_a", rise_a, '0);
      chk("rst_fall_a", fall_a, '0);
      chk("rst_sync_b", sync_b, RV_B);
      chk("rst_rise_b", rise_b, '0);
      chk("rst_fall_b", fall_b, '0);
    end else begin
      chk("excl_a", rise_a & fall_a, '0);
      chk("excl_b", rise_b & fall_b, '0);
      rcnt_a += $countones(rise_a); fcnt_a += $countones(fall_a);
      rcnt_b += $countones(rise_b); fcnt_b += $countones(fall_b);
      if (edge_cnt < S_A) begin
        chk("fill_sync_a", sync_a, RV_A);
        chk("fill_edge_a", rise_a | fall_a, '0);
      end else if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL queue_a at %0t: no expected entry available", $time);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("sync_a", sync_a, e.sync);
        chk("rise_a", rise_a, e.rise);
        chk("fall_a", fall_a, e.fall);
      end
      if (edge_cnt < S_B) begin
        chk("fill_sync_b", sync_b, RV_B);
        chk("fill_edge_b", rise_b | fall_b, '0);
      end else if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL queue_b at %0t: no expected entry available", $time);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("sync_b", sync_b, e.sync);
        chk("rise_b", rise_b, e.rise);
        chk("fall_b", fall_b, e.fall);
      end
    end
  end

  // Stimulus
  initial begin
    reset_i = 1'b0;
    async_i = '1;
    repeat (5) @(negedge clk);
    async_i = '0;
    reset_i = 1'b1;

    // Rising edge between edges 3 and 4, then falling edge
    repeat (3) @(posedge clk);
    #3 async_i = '1;
    repeat (6) @(negedge clk);
    async_i = '0;
    repeat (6) @(negedge clk);

    // 0.4-cycle pulse between edges (never sampled)
    @(posedge clk);
    #3 async_i = '1;
    #4 async_i = '0;
    repeat (4) @(negedge clk);

    // Short pulse straddling one edge
    @(posedge clk);
    #7 async_i = '1;
    #4 async_i = '0;
    repeat (5) @(negedge clk);

    // 3-cycle pulse
    async_i = '1;
    repeat (3) @(negedge clk);
    async_i = '0;
    repeat (6) @(negedge clk);

    // Independent bit patterns
    async_i = 4'b1010;
    repeat (4) @(negedge clk);
    async_i = 4'b0110;
    repeat (4) @(negedge clk);

    // Toggle every 2 cycles
    for (int i = 0; i < 12; i++) begin
      async_i = ~async_i;
      repeat (2) @(negedge clk);
    end

    // Reset asserted mid-propagation with a new level in flight
    async_i = 4'b0001;
    repeat (4) @(negedge clk);
    async_i = 4'b1110;
    @(posedge clk);
    #3 reset_i = 1'b0;
    #1;
    chk("async_rst_sync_a", sync_a, RV_A);
    chk("async_rst_edge_a", rise_a | fall_a, '0);
    chk("async_rst_sync_b", sync_b, RV_B);
    chk("async_rst_edge_b", rise_b | fall_b, '0);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    repeat (6) @(negedge clk);

    // Random stream at an unrelated timing, 1000 transitions
    for (int i = 0; i < 1000; i++) begin
      int d;
      d = $urandom_range(1, 37);
      #d;
      if (($time % 5) == 0) #1;
      async_i = async_i ^ W'($urandom_range(1, 15));
    end

    // Random synchronous stream
    repeat (300) begin
      @(negedge clk);
      async_i = W'($urandom);
    end

    // Settle, then check stable-point tracking and strobe balance
    repeat (8) @(negedge clk);
    chk("stable_sync_a", sync_a, async_i);
    chk("stable_sync_b", sync_b, async_i);
    chk_int("balance_a", rcnt_a - fcnt_a, $countones(async_i) - $countones(RV_A));
    chk_int("balance_b", rcnt_b - fcnt_b, $countones(async_i) - $countones(RV_B));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cdc_synchron.md
Name: cdc_synchron

Overview:
- Single-bit (optionally vectored) clock-domain-crossing synchronizer with edge detection.
- Brings an asynchronous input into the `sysClk_i` domain through a multi-flop chain.
- Outputs the synchronized level plus single-cycle rising- and falling-edge strobes.
- Used on inputs from foreign clock domains, e.g. SPI MISO sampled in the master's SPI clock domain.

Parameters:
- `WIDTH`, 1: number of independent bits synchronized in parallel; each bit is handled identically.
- `STAGES`, 2: synchronizer flop count, legal range 2..4.
- `RESET_VALUE`, 0: level loaded into every stage and the history flop on reset; one value applies to all bits.

Ports:
- `sysClk_i`  input  1  destination-domain clock; all state updates on its rising edge.
- `reset_i`  input  1  asynchronous, active-low reset.
- `async_i`  input  WIDTH  asynchronous input; no timing relationship to `sysClk_i`.
- `sync_o`  output  WIDTH  synchronized level (final chain stage).
- `rising_o`  output  WIDTH  one-cycle pulse per bit on a 0->1 transition of `sync_o`.
- `falling_o`  output  WIDTH  one-cycle pulse per bit on a 1->0 transition of `sync_o`.

Behaviour:
- State per bit:
  - `stage[0..STAGES-1]`: synchronizer chain.
  - `prev`: history flop.
- Reset: `reset_i`=0 asynchronously forces every stage and `prev` to `RESET_VALUE`.
  - While reset is held: `sync_o`=`RESET_VALUE`, `rising_o`=0, `falling_o`=0.
  - Release is sampled on `sysClk_i`.
  - No edge pulse may be generated by reset assertion or release.
- Each `sysClk_i` rising edge, with reset inactive:
  - `stage[0]` <= `async_i`
  - `stage[i]` <= `stage[i-1]`
  - `prev` <= `stage[STAGES-1]`
- Outputs:
  - `sync_o` = `stage[STAGES-1]` (registered).
  - `rising_o` = `stage[STAGES-1]` & ~`prev`; `falling_o` = ~`stage[STAGES-1]` & `prev`.
  - Both edge outputs are combinational from flops only, with no logic on `async_i`.
- Latency: a level on `async_i` that is stable across edge k appears on `sync_o` after edge k+STAGES-1. Including sampling uncertainty, `sync_o` follows within STAGES..STAGES+1 edges of the input change.
- The edge pulse is asserted in the same cycle `sync_o` first shows the new level and lasts exactly one `sysClk_i` cycle.
- `rising_o` and `falling_o` are never both 1 for the same bit.
- Input pulses shorter than one `sysClk_i` period may be lost. Pulses of 2 or more periods are always reproduced: one rising and one falling strobe, separated by the pulse width ±1 cycle.
- Input toggling every 2 cycles: `sync_o` toggles every 2 cycles; strobes alternate rising and falling with no gap loss.
- Reset asserted mid-propagation: the in-flight value is discarded and no strobe is produced. After release, the output follows the current `async_i` with normal latency. A strobe appears only if `async_i` differs from `RESET_VALUE`.
- No combinational path from `async_i` to any output.
- Chain flops carry a synchronizer attribute/naming so synthesis keeps them adjacent and does not retime or merge them.
- Bits of a vector are synchronized independently; no coherency between bits is guaranteed.

Test Plan:
- Reset: hold `reset_i`=0 with `async_i`=1 for 5 clocks -> `sync_o`=0, `rising_o`=0, `falling_o`=0 throughout; assert mid-cycle and check outputs clear immediately.
- Rising latency: release reset with `async_i`=0; set `async_i`=1 between edges 3 and 4 -> `sync_o`=1 from edge 5 (STAGES=2); `rising_o`=1 for exactly that one cycle; `falling_o`=0.
- Falling path: after the previous scenario, drop `async_i` to 0 -> `sync_o`=0 two edges later; one-cycle `falling_o`; `rising_o` stays 0.
- Short/long pulses: 0.4-cycle pulse (may drop) and 3-cycle pulse -> 3-cycle pulse yields exactly one `rising_o` and one `falling_o`, 3 cycles apart; the short pulse yields either nothing or one matched rise/fall pair.
- Random stream at an async clock ratio (e.g. 10 ns vs 37 ns), 1000 transitions -> count of `rising_o` equals count of `falling_o` ±1; `sync_o` equals the input delayed 2..3 cycles at every stable point.
- Parameters: STAGES=3 with `RESET_VALUE`=1 -> after reset `sync_o`=1 with no strobe; `async_i`=0 gives `falling_o` one cycle later than with STAGES=2.
